instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rv32i_fetch_pkg.sv | 14 +
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package rv32i_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC sequencing, single-entry output register with
// valid/ready handshake, redirect/halt control and sticky fetch fault.
//
// state  | meaning
// BOOT   | one idle cycle after reset release, no read
// RUN    | fetching sequentially from pc
// HALTED | no new reads; pending instruction may still drain
// FAULT  | terminal until reset; fetch_fault set, output squashed
module instr_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_read_enable,
  output logic [ADDR_WIDTH-1:0] imem_read_address,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt_req,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [31:0]           if_pc,
  output logic                  fetch_fault,
  output logic [31:0]           fault_pc,
  output logic [31:0]           fetch_count
);

  fetch_state_t          state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [31:0]           if_pc_q, if_pc_d;
  logic [31:0]           fault_pc_q, fault_pc_d;
  logic [31:0]           count_q, count_d;
  logic                  load;
  logic                  handshake;
  logic                  pc_oob;

  assign handshake = valid_q && if_ready;
  // Any bit above the word-address range means the PC left instruction memory.
  assign pc_oob    = (pc_q[31:ADDR_WIDTH+2] != '0);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    if_pc_d    = if_pc_q;
    fault_pc_d = fault_pc_q;
    count_d    = handshake ? count_q + 32'd1 : count_q;
    load       = 1'b0;
    if (handshake) valid_d = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN, HALTED: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d    = FAULT;
            fault_pc_d = redirect_pc;
          end else begin
            pc_d    = redirect_pc;
            state_d = (state_q == HALTED && halt_req) ? HALTED : RUN;
          end
        end else if (state_q == HALTED) begin
          if (!halt_req) state_d = RUN;
        end else if (pc_oob) begin
          state_d    = FAULT;
          fault_pc_d = pc_q;
          valid_d    = 1'b0;
        end else if (halt_req) begin
          state_d = HALTED;
        end else if (!valid_q || if_ready) begin
          load    = 1'b1;
          valid_d = 1'b1;
          instr_d = imem_read_data;
          if_pc_d = pc_q;
          pc_d    = pc_q + PC_STEP;
        end
      end
      FAULT: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      if_pc_q    <= '0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      if_pc_q    <= if_pc_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign imem_read_enable  = load;
  assign imem_read_address = pc_q[ADDR_WIDTH+1:2];
  assign if_valid          = valid_q;
  assign if_instr          = instr_q;
  assign if_pc             = if_pc_q;
  assign fetch_fault       = (state_q == FAULT);
  assign fault_pc          = fault_pc_q;
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand-written
// sequences for async reset, halted redirect and out-of-range fault.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_read_enable;
  logic [11:0] imem_read_address;
  logic [31:0] imem_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_read_enable(imem_read_enable), .imem_read_address(imem_read_address),
    .imem_read_data(imem_read_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memw(input logic [11:0] a);
    case (a)
      12'd0:   memw = 32'h0000_0013;
      12'd1:   memw = 32'h0010_0093;
      12'd2:   memw = 32'h0020_0113;
      12'd3:   memw = 32'h0030_0193;
      default: memw = {20'hC0DE0, a};
    endcase
  endfunction

  assign imem_read_data = memw(imem_read_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        rdy, halt, rv;
    logic [31:0] rpc;
    logic        ren, vld;
    logic [31:0] ipc, cnt;
    logic        flt;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic halt, input logic rv,
                              input logic [31:0] rpc, input logic ren, input logic vld,
                              input logic [31:0] ipc, input logic [31:0] cnt,
                              input logic flt);
    vec_t v;
    v.rdy = rdy; v.halt = halt; v.rv = rv; v.rpc = rpc;
    v.ren = ren; v.vld = vld; v.ipc = ipc; v.cnt = cnt; v.flt = flt;
    return v;
  endfunction

  vec_t vecs[23];

  initial begin
    // one entry per cycle after reset release; expectations seen mid-cycle
    vecs[0]  = mk(1,0,0,32'h0,  0,0,32'h0, 0,0);  // BOOT, no read
    vecs[1]  = mk(1,0,0,32'h0,  1,0,32'h0, 0,0);
    vecs[2]  = mk(1,0,0,32'h0,  1,1,32'h0, 0,0);
    vecs[3]  = mk(1,0,0,32'h0,  1,1,32'h4, 1,0);
    vecs[4]  = mk(0,0,0,32'h0,  0,1,32'h8, 2,0);  // stall x3
    vecs[5]  = mk(0,0,0,32'h0,  0,1,32'h8, 2,0);
    vecs[6]  = mk(0,0,0,32'h0,  0,1,32'h8, 2,0);
    vecs[7]  = mk(1,0,0,32'h0,  1,1,32'h8, 2,0);
    vecs[8]  = mk(1,0,0,32'h0,  1,1,32'hC, 3,0);
    vecs[9]  = mk(1,0,1,32'h40, 0,1,32'h10,4,0);  // redirect + handshake
    vecs[10] = mk(1,0,0,32'h0,  1,0,32'h0, 5,0);
    vecs[11] = mk(1,0,0,32'h0,  1,1,32'h40,5,0);
    vecs[12] = mk(0,1,0,32'h0,  0,1,32'h44,6,0);  // halt 5 cycles
    vecs[13] = mk(0,1,0,32'h0,  0,1,32'h44,6,0);
    vecs[14] = mk(1,1,0,32'h0,  0,1,32'h44,6,0);
    vecs[15] = mk(1,1,0,32'h0,  0,0,32'h0, 7,0);
    vecs[16] = mk(1,1,0,32'h0,  0,0,32'h0, 7,0);
    vecs[17] = mk(1,0,0,32'h0,  0,0,32'h0, 7,0);
    vecs[18] = mk(1,0,0,32'h0,  1,0,32'h0, 7,0);
    vecs[19] = mk(1,0,0,32'h0,  1,1,32'h48,7,0);
    vecs[20] = mk(1,0,1,32'h42, 0,1,32'h4C,8,0);  // misaligned redirect
    vecs[21] = mk(1,0,1,32'h0,  0,0,32'h0, 9,1);  // ignored in FAULT
    vecs[22] = mk(1,0,0,32'h0,  0,0,32'h0, 9,1);

    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; if_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_ren",   {31'b0, imem_read_enable}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      if_ready = vecs[i].rdy; halt_req = vecs[i].halt;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      @(negedge clock);
      chk($sformatf("v%0d_ren", i),   {31'b0, imem_read_enable}, {31'b0, vecs[i].ren});
      chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].vld});
      chk($sformatf("v%0d_count", i), fetch_count, vecs[i].cnt);
      chk($sformatf("v%0d_fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].flt});
      if (vecs[i].vld) begin
        chk($sformatf("v%0d_pc", i),    if_pc, vecs[i].ipc);
        chk($sformatf("v%0d_instr", i), if_instr, memw(vecs[i].ipc[13:2]));
      end
      tick();
    end
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("fault_pc_mis", fault_pc, 32'h42);
    chk("fault_sticky", {31'b0, fetch_fault}, 32'h1);

    // asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    chk("arst_fault",    {31'b0, fetch_fault}, 32'h0);
    chk("arst_fault_pc", fault_pc, 32'h0);
    chk("arst_count",    fetch_count, 32'h0);
    chk("arst_if_pc",    if_pc, 32'h0);
    chk("arst_addr",     {20'b0, imem_read_address}, 32'h0);

    // redirect while halted keeps HALTED and moves pc
    @(posedge clock); #1;
    halt_req = 1'b1; reset = 1'b1;
    @(negedge clock); chk("hb_boot_ren", {31'b0, imem_read_enable}, 32'h0);
    tick();
    @(negedge clock); chk("hb_run_ren", {31'b0, imem_read_enable}, 32'h0);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clock); chk("hb_redir_ren", {31'b0, imem_read_enable}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("hb_hold_ren",  {31'b0, imem_read_enable}, 32'h0);
    chk("hb_hold_addr", {20'b0, imem_read_address}, 32'h40);
    tick();
    halt_req = 1'b0;
    @(negedge clock); chk("hb_leave_ren", {31'b0, imem_read_enable}, 32'h0);
    tick();
    @(negedge clock);
    chk("hb_res_ren",  {31'b0, imem_read_enable}, 32'h1);
    chk("hb_res_addr", {20'b0, imem_read_address}, 32'h40);
    tick();
    @(negedge clock);
    chk("hb_res_valid", {31'b0, if_valid}, 32'h1);
    chk("hb_res_pc",    if_pc, 32'h100);
    chk("hb_res_instr", if_instr, memw(12'h40));

    // sequential fetch running off the end of instruction memory
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h3FF8;
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("oob_ren0",  {31'b0, imem_read_enable}, 32'h1);
    chk("oob_addr0", {20'b0, imem_read_address}, 32'hFFE);
    tick();
    @(negedge clock);
    chk("oob_pc0", if_pc, 32'h3FF8);
    tick();
    @(negedge clock);
    chk("oob_pc1",  if_pc, 32'h3FFC);
    chk("oob_noread", {31'b0, imem_read_enable}, 32'h0);
    tick();
    @(negedge clock);
    chk("oob_fault",    {31'b0, fetch_fault}, 32'h1);
    chk("oob_fault_pc", fault_pc, 32'h4000);
    chk("oob_valid",    {31'b0, if_valid}, 32'h0);
    chk("oob_ren",      {31'b0, imem_read_enable}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
